cu_fsm: RTL

- Multi-cycle control sequencer for the OTTER RV32I core.
- Steps each instruction through fetch, execute, optional load writeback and optional interrupt entry.
- Issues all state-dependent write/read strobes: PC, register file, data memory, CSR.
- Sits beside the combinational control decoder, which supplies mux selects; this block owns timing and write enables only.

---
 rtl/cu_fsm.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cu_fsm.sv
// cu_fsm: multi-cycle control sequencer for the OTTER RV32I core.
// Walks each instruction through fetch, execute, optional load writeback and
// optional interrupt entry, and owns every state-dependent write/read strobe.
// Mux selects come from the separate combinational decoder; this block only
// decides when things happen. A bounded wait counter turns a memory that
// never answers into a sticky fault and a halt.
module cu_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       intr,
    input  logic       mie,
    input  logic       mem_rdy1,
    input  logic       mem_rdy2,
    output logic       rst,
    output logic       pcWrite,
    output logic       regWrite,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       memWE2,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       fault
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR,
        ST_HALT
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  wait_cnt_reg;
    logic           fault_reg;

    logic           waiting;    // current access is stalled on its ready
    logic           complete;   // instruction retires this cycle (pcWrite)
    logic           is_mret;    // completing instruction is MRET
    logic           timeout;    // stall has run out of budget

    // Strobes and next state decoded from the current state and live inputs.
    always_comb begin
        rst        = 1'b0;
        pcWrite    = 1'b0;
        regWrite   = 1'b0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        memWE2     = 1'b0;
        csr_WE     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        state_next = state_reg;
        waiting    = 1'b0;
        complete   = 1'b0;
        is_mret    = 1'b0;

        case (state_reg)
            ST_INIT: begin
                rst        = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                memRDEN1 = 1'b1;
                if (mem_rdy1) state_next = ST_EXEC;
                else          waiting    = 1'b1;
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_JAL, OPC_JALR: begin
                        pcWrite  = 1'b1;
                        regWrite = 1'b1;
                        complete = 1'b1;
                    end
                    OPC_BRANCH: begin
                        pcWrite  = 1'b1;
                        complete = 1'b1;
                    end
                    OPC_STORE: begin
                        // Write enable is held until the data port acknowledges.
                        memWE2 = 1'b1;
                        if (mem_rdy2) begin
                            pcWrite  = 1'b1;
                            complete = 1'b1;
                        end else begin
                            waiting = 1'b1;
                        end
                    end
                    OPC_LOAD: begin
                        memRDEN2   = 1'b1;
                        state_next = ST_WB;
                    end
                    OPC_SYSTEM: begin
                        pcWrite  = 1'b1;
                        complete = 1'b1;
                        if (func3 == 3'b001) begin
                            regWrite = 1'b1;
                            csr_WE   = 1'b1;
                        end else if (func3 == 3'b000) begin
                            mret_exec = 1'b1;
                            is_mret   = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcodes retire as a NOP.
                        pcWrite  = 1'b1;
                        complete = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                memRDEN2 = 1'b1;
                if (mem_rdy2) begin
                    regWrite = 1'b1;
                    pcWrite  = 1'b1;
                    complete = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_INTR: begin
                int_taken  = 1'b1;
                pcWrite    = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        // Interrupts are only sampled at retirement; MRET never traps directly.
        if (complete) begin
            if (intr && mie && !is_mret) state_next = ST_INTR;
            else                         state_next = ST_FETCH;
        end

        // A ready arriving on the last allowed cycle clears waiting, so it wins.
        timeout = waiting && (wait_cnt_reg == WAIT_LAST);
        if (timeout) state_next = ST_HALT;
    end

    assign fault = fault_reg;

    // State register, stall counter and sticky fault flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= ST_INIT;
            wait_cnt_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (timeout) fault_reg <= 1'b1;
            if (state_next != state_reg) wait_cnt_reg <= '0;
            else if (waiting)            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

endmodule
